io_port_peripheral: RTL and testbench
=====================================

# io_port_peripheral

Memory-less I/O responder on the far side of the CPU's 16-bit `in`/`out` ports.
- Output direction: captures every CPU output-register write into a small FIFO and drains it to an external consumer over a valid/ready handshake.
- Input direction: accepts one word from an external producer over valid/ready, holds it, and presents it on the CPU `in` port until the CPU consumes it.
- Placement: sits beside `TopLevel`, wired to its `in`/`out` ports and to the control unit's output-write and input-read strobes.

## Interface
Parameters:
- `WIDTH`, 16, data word width (matches CPU datapath).
- `DEPTH`, 4, TX FIFO entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_out`  in  WIDTH  value being written to the CPU output register.
- `cpu_out_write`  in  1  one-cycle strobe; `cpu_out` is valid this cycle.
- `cpu_in_read`  in  1  one-cycle strobe; CPU has consumed `cpu_in`.
- `cpu_in`  out  WIDTH  held RX word, or 0 when none is pending.
- `rx_pending`  out  1  an RX word is held.
- `ext_tx_data`  out  WIDTH  FIFO head word.
- `ext_tx_valid`  out  1  FIFO not empty.
- `ext_tx_ready`  in  1  consumer accepts head.
- `ext_rx_data`  in  WIDTH  producer word.
- `ext_rx_valid`  in  1  producer word valid.
- `ext_rx_ready`  out  1  holding register empty.
- `overflow`  out  1  sticky; a CPU write was dropped.

## Operation
TX path:
- Circular buffer with `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap naturally) and `count` (0..DEPTH, log2 DEPTH+1 bits).
- Push = `cpu_out_write && (count<DEPTH || pop)`.
- Pop = `ext_tx_valid && ext_tx_ready`.
- `cpu_out_write` while full with no simultaneous pop: the word is dropped, pointers and count are unchanged, and `overflow` is set.
- `overflow` clears only on reset.
- Simultaneous push and pop at any count, including full: both occur and `count` is unchanged.
- `ext_tx_data` is the entry at `rd_ptr`. It is held stable while `ext_tx_valid && !ext_tx_ready`.
- Words leave in CPU write order.

RX path, two-state FSM:
- RX_EMPTY: `ext_rx_ready=1`, `cpu_in=0`, `rx_pending=0`. When `ext_rx_valid` is asserted, capture `ext_rx_data` and go to RX_FULL.
- RX_FULL: `ext_rx_ready=0`, `cpu_in`=held word, `rx_pending=1`. When `cpu_in_read` is asserted, go to RX_EMPTY. Producer words offered in this state are not accepted, and the producer must hold them.
- `cpu_in_read` in RX_EMPTY is ignored.

## Timing
- Reset values (asserted immediately and asynchronously, including mid-transfer): `count=0`, pointers 0, `ext_tx_valid=0`, `overflow=0`, RX_EMPTY, `cpu_in=0`, `rx_pending=0`, `ext_rx_ready=1`.
- FIFO contents are not reset; `ext_tx_data` is don't-care while `ext_tx_valid=0`.
- Any partially handshaken transfer is lost on reset.
- TX latency: write strobe at edge N gives `ext_tx_valid=1` and data visible after edge N. No bypass: earliest pop at edge N+1.
- RX latency: capture at edge N gives `cpu_in` valid after edge N. `cpu_in_read` at edge M gives `cpu_in=0` and `ext_rx_ready=1` after edge M. Next capture is no earlier than edge M+1.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `ext_tx_ready` or `ext_rx_valid` to any output.

## Structure
- Shared package `io_pkg`:
  - `IO_WIDTH=16` and `IO_DEPTH=4` defaults.
  - RX state encoding constants `RX_EMPTY=1'b0`, `RX_FULL=1'b1`.
- Sub-module `io_tx_fifo`: parameterised storage, pointers, count, full/empty and overflow logic.
- The RX FSM and holding register stay in the top module.

## Test plan
- Reset: drive `reset_n=0` mid-operation → all outputs at the reset values above on the same cycle; `ext_rx_ready=1`.
- Ordered drain with backpressure: write 0x1234 then 0xABCD with `ext_tx_ready=0` → `ext_tx_valid=1` and `ext_tx_data=0x1234` stable for ≥3 cycles. Raise ready → 0x1234 then 0xABCD transfer on consecutive edges; `ext_tx_valid=0` afterwards.
- Overflow: write 0x0001..0x0004, then 0x5555, with ready=0 → `overflow=1`. Drain yields exactly 0x0001..0x0004; `overflow` stays 1.
- Full plus simultaneous: fill with 4 words, then on one edge write 0x7777 while `ext_tx_ready=1` → `count` stays 4 and `overflow=0`. 0x7777 emerges fourth after the original head, i.e. after the remaining three words.
- RX handshake: `ext_rx_valid=1`, `ext_rx_data=0x00FF` → next cycle `cpu_in=0x00FF`, `rx_pending=1`, `ext_rx_ready=0`. Offer 0x0F0F → not accepted. Pulse `cpu_in_read` → `cpu_in=0`, `ext_rx_ready=1`, then 0x0F0F is captured.
- Pointer wrap: push and pop 10 words 0x0100..0x0109 with random ready → output sequence identical and `count` returns to 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O port peripheral: default sizes and the
// RX holding-register state encoding.
package io_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 4;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/io_tx_fifo.sv
// Circular TX buffer between CPU output-register writes and the external
// consumer; drops writes when full (unless a pop frees a slot) and flags it.
module io_tx_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             push;
  logic             pop;

  assign pop  = (count_reg != '0) && rd_ready;
  // A pop on the same edge frees the slot, so a write into a full buffer still lands.
  assign push = wr_en && ((count_reg != FULL_COUNT) || pop);

  // Storage is deliberately not reset; the head is only meaningful while valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (wr_en && !push) overflow_reg <= 1'b1;
    end
  end

  assign rd_data  = mem_reg[rd_ptr_reg];
  assign rd_valid = (count_reg != '0);
  assign overflow = overflow_reg;

endmodule

// File: rtl/io_port_peripheral.sv
// I/O responder behind the CPU in/out ports: buffers CPU output writes to an
// external consumer and holds one producer word for the CPU to read.
module io_port_peripheral
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] cpu_out,
  input  logic             cpu_out_write,
  input  logic             cpu_in_read,
  output logic [WIDTH-1:0] cpu_in,
  output logic             rx_pending,
  output logic [WIDTH-1:0] ext_tx_data,
  output logic             ext_tx_valid,
  input  logic             ext_tx_ready,
  input  logic [WIDTH-1:0] ext_rx_data,
  input  logic             ext_rx_valid,
  output logic             ext_rx_ready,
  output logic             overflow
);

  rx_state_e        rx_state_reg;
  logic [WIDTH-1:0] cpu_in_reg;
  logic             rx_pending_reg;
  logic             ext_rx_ready_reg;

  io_tx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_tx_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (cpu_out_write),
    .wr_data  (cpu_out),
    .rd_ready (ext_tx_ready),
    .rd_data  (ext_tx_data),
    .rd_valid (ext_tx_valid),
    .overflow (overflow)
  );

  // Outputs are registered alongside the state so nothing depends on ext_rx_valid combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_reg     <= RX_EMPTY;
      cpu_in_reg       <= '0;
      rx_pending_reg   <= 1'b0;
      ext_rx_ready_reg <= 1'b1;
    end else begin
      case (rx_state_reg)
        RX_EMPTY: begin
          if (ext_rx_valid) begin
            rx_state_reg     <= RX_FULL;
            cpu_in_reg       <= ext_rx_data;
            rx_pending_reg   <= 1'b1;
            ext_rx_ready_reg <= 1'b0;
          end
        end
        RX_FULL: begin
          if (cpu_in_read) begin
            rx_state_reg     <= RX_EMPTY;
            cpu_in_reg       <= '0;
            rx_pending_reg   <= 1'b0;
            ext_rx_ready_reg <= 1'b1;
          end
        end
        default: begin
          rx_state_reg     <= RX_EMPTY;
          cpu_in_reg       <= '0;
          rx_pending_reg   <= 1'b0;
          ext_rx_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_in       = cpu_in_reg;
  assign rx_pending   = rx_pending_reg;
  assign ext_rx_ready = ext_rx_ready_reg;

endmodule

// File: tb/tb_io_port_peripheral.sv
// Directed bench for io_port_peripheral: TX ordering/backpressure, overflow,
// full-with-pop, RX handshake, async reset and pointer wrap.
module tb_io_port_peripheral;

  logic        clock;
  logic        reset_n;
  logic [15:0] cpu_out;
  logic        cpu_out_write;
  logic        cpu_in_read;
  logic [15:0] cpu_in;
  logic        rx_pending;
  logic [15:0] ext_tx_data;
  logic        ext_tx_valid;
  logic        ext_tx_ready;
  logic [15:0] ext_rx_data;
  logic        ext_rx_valid;
  logic        ext_rx_ready;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  io_port_peripheral #(.WIDTH(16), .DEPTH(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu_out       (cpu_out),
    .cpu_out_write (cpu_out_write),
    .cpu_in_read   (cpu_in_read),
    .cpu_in        (cpu_in),
    .rx_pending    (rx_pending),
    .ext_tx_data   (ext_tx_data),
    .ext_tx_valid  (ext_tx_valid),
    .ext_tx_ready  (ext_tx_ready),
    .ext_rx_data   (ext_rx_data),
    .ext_rx_valid  (ext_rx_valid),
    .ext_rx_ready  (ext_rx_ready),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_seq [4];
    int   wr_idx;
    int   rd_idx;
    int   mcount;
    bit   rdy;
    bit   wr;
    bit   pop;

    reset_n       = 1'b0;
    cpu_out       = '0;
    cpu_out_write = 1'b0;
    cpu_in_read   = 1'b0;
    ext_tx_ready  = 1'b0;
    ext_rx_data   = '0;
    ext_rx_valid  = 1'b0;
    tick();
    tick();
    check("rst_tx_valid", 32'(ext_tx_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_cpu_in", 32'(cpu_in), 32'd0);
    check("rst_rx_pending", 32'(rx_pending), 32'd0);
    check("rst_rx_ready", 32'(ext_rx_ready), 32'd1);
    check("rst_count", 32'(dut.u_tx_fifo.count_reg), 32'd0);
    reset_n = 1'b1;
    tick();

    // Ordered drain under backpressure.
    cpu_out_write = 1'b1;
    cpu_out = 16'h1234;
    tick();
    cpu_out = 16'hABCD;
    tick();
    cpu_out_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(ext_tx_valid), 32'd1);
      check("bp_hold_data", 32'(ext_tx_data), 32'h1234);
      tick();
    end
    check("bp_head", 32'(ext_tx_data), 32'h1234);
    ext_tx_ready = 1'b1;
    tick();
    check("bp_second_valid", 32'(ext_tx_valid), 32'd1);
    check("bp_second_data", 32'(ext_tx_data), 32'hABCD);
    tick();
    check("bp_empty", 32'(ext_tx_valid), 32'd0);
    ext_tx_ready = 1'b0;

    // Overflow: fifth write while full is dropped.
    cpu_out_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cpu_out = 16'(i);
      tick();
    end
    check("ovf_before", 32'(overflow), 32'd0);
    cpu_out = 16'h5555;
    tick();
    cpu_out_write = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(dut.u_tx_fifo.count_reg), 32'd4);
    ext_tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain_valid", 32'(ext_tx_valid), 32'd1);
      check("ovf_drain_data", 32'(ext_tx_data), 32'(i));
      tick();
    end
    check("ovf_drained", 32'(ext_tx_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    ext_tx_ready = 1'b0;

    // Asynchronous reset in the middle of activity.
    cpu_out_write = 1'b1;
    cpu_out = 16'hC001;
    ext_rx_valid = 1'b1;
    ext_rx_data = 16'hBEEF;
    tick();
    ext_rx_valid = 1'b0;
    cpu_out = 16'hC002;
    tick();
    cpu_out_write = 1'b0;
    check("pre_rst_pending", 32'(rx_pending), 32'd1);
    check("pre_rst_cpu_in", 32'(cpu_in), 32'hBEEF);
    check("pre_rst_tx_valid", 32'(ext_tx_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(ext_tx_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_cpu_in", 32'(cpu_in), 32'd0);
    check("mid_rst_pending", 32'(rx_pending), 32'd0);
    check("mid_rst_rx_ready", 32'(ext_rx_ready), 32'd1);
    check("mid_rst_count", 32'(dut.u_tx_fifo.count_reg), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Full plus simultaneous push and pop.
    cpu_out_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cpu_out = 16'(i * 16'h1111);
      tick();
    end
    cpu_out = 16'h7777;
    ext_tx_ready = 1'b1;
    tick();
    cpu_out_write = 1'b0;
    check("full_pp_count", 32'(dut.u_tx_fifo.count_reg), 32'd4);
    check("full_pp_overflow", 32'(overflow), 32'd0);
    exp_seq[0] = 16'h2222;
    exp_seq[1] = 16'h3333;
    exp_seq[2] = 16'h4444;
    exp_seq[3] = 16'h7777;
    for (int i = 0; i < 4; i++) begin
      check("full_pp_valid", 32'(ext_tx_valid), 32'd1);
      check("full_pp_data", 32'(ext_tx_data), 32'(exp_seq[i]));
      tick();
    end
    check("full_pp_empty", 32'(ext_tx_valid), 32'd0);
    ext_tx_ready = 1'b0;

    // RX handshake.
    check("rx_ready_idle", 32'(ext_rx_ready), 32'd1);
    ext_rx_valid = 1'b1;
    ext_rx_data = 16'h00FF;
    tick();
    check("rx_cap_data", 32'(cpu_in), 32'h00FF);
    check("rx_cap_pending", 32'(rx_pending), 32'd1);
    check("rx_cap_ready", 32'(ext_rx_ready), 32'd0);
    ext_rx_data = 16'h0F0F;
    tick();
    check("rx_hold_data", 32'(cpu_in), 32'h00FF);
    cpu_in_read = 1'b1;
    tick();
    cpu_in_read = 1'b0;
    check("rx_read_cpu_in", 32'(cpu_in), 32'd0);
    check("rx_read_ready", 32'(ext_rx_ready), 32'd1);
    check("rx_read_pending", 32'(rx_pending), 32'd0);
    tick();
    check("rx_next_data", 32'(cpu_in), 32'h0F0F);
    ext_rx_valid = 1'b0;
    cpu_in_read = 1'b1;
    tick();
    tick();
    cpu_in_read = 1'b0;
    check("rx_empty_read_pending", 32'(rx_pending), 32'd0);
    check("rx_empty_read_ready", 32'(ext_rx_ready), 32'd1);
    check("rx_empty_read_cpu_in", 32'(cpu_in), 32'd0);
    ext_rx_valid = 1'b1;
    ext_rx_data = 16'h00AA;
    tick();
    ext_rx_valid = 1'b0;
    check("rx_after_ignored_read", 32'(cpu_in), 32'h00AA);
    cpu_in_read = 1'b1;
    tick();
    cpu_in_read = 1'b0;

    // Pointer wrap with random backpressure.
    wr_idx = 0;
    rd_idx = 0;
    mcount = 0;
    for (int cyc = 0; cyc < 200 && rd_idx < 10; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      pop = (mcount > 0) && rdy;
      wr  = (wr_idx < 10) && ((mcount < 4) || pop);
      ext_tx_ready  = rdy;
      cpu_out_write = wr;
      cpu_out       = 16'(32'h0100 + wr_idx);
      check("wrap_valid", 32'(ext_tx_valid), 32'(mcount > 0));
      if (pop) begin
        check("wrap_data", 32'(ext_tx_data), 32'h0100 + 32'(rd_idx));
        rd_idx++;
      end
      if (wr) wr_idx++;
      mcount = mcount + int'(wr) - int'(pop);
      tick();
    end
    cpu_out_write = 1'b0;
    ext_tx_ready = 1'b0;
    check("wrap_all_drained", 32'(rd_idx), 32'd10);
    check("wrap_count_zero", 32'(dut.u_tx_fifo.count_reg), 32'd0);
    check("wrap_valid_end", 32'(ext_tx_valid), 32'd0);
    check("wrap_no_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
